// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES byte-stream I/O blocks: collector FSM states
// and default stream geometry.
package aes_io_pkg;

  localparam int AES_BYTE_W = 8;
  localparam int AES_NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/aes_byte_shreg.sv
// Byte-wide shift register with parallel output. New bytes enter at the LSB end,
// so the first byte shifted in ends up in the MSB byte.
module aes_byte_shreg
  import aes_io_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES,
  parameter int BYTE_W = AES_BYTE_W
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     shift_en_i,
  input  logic [BYTE_W-1:0]        din_i,
  output logic [NBYTES*BYTE_W-1:0] dout_o
);

  localparam int W = NBYTES * BYTE_W;

  logic [W-1:0] data_q;

  // NOTE: this data register is cleared on reset only because the collector must
  // present an all-zero block out of reset; plain datapath storage is usually left unreset.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      data_q <= {data_q[W-BYTE_W-1:0], din_i};
    end
  end

  assign dout_o = data_q;

endmodule

// File: rtl/aes_byte_collector.sv
// Collects the AES core's byte-serial d_out stream into one parallel block and
// holds it under a valid/ready handshake, flagging dropped and truncated streams.
module aes_byte_collector
  import aes_io_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES,
  parameter int BYTE_W = AES_BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        in_byte,
  input  logic                     in_vld,
  input  logic                     clr,
  output logic [NBYTES*BYTE_W-1:0] blk_out,
  output logic                     blk_vld,
  input  logic                     blk_rdy,
  output logic                     busy,
  output logic                     ovf,
  output logic                     short_err
);

  localparam int CNT_W = $clog2(NBYTES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q;
  logic             ovf_q, ovf_d;
  logic             short_q, short_d;
  logic             shift_en;
  logic             start;
  logic             accept;

  // d_vld is a level; only its rising edge marks a new stream.
  assign start  = in_vld & ~vld_q;
  assign accept = (state_q == HOLD) & blk_rdy;

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    ovf_d    = clr ? 1'b0 : ovf_q;
    short_d  = clr ? 1'b0 : short_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_en = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = CAPT;
        end
      end
      CAPT: begin
        if (in_vld) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_W'(NBYTES - 1)) begin
            cnt_d   = CNT_W'(NBYTES);
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          short_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (accept && start) begin
          shift_en = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = CAPT;
        end else if (accept) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (start) begin
          // Consumer still owns the held block: the new stream is lost.
          ovf_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= in_vld;
      ovf_q   <= ovf_d;
      short_q <= short_d;
    end
  end

  aes_byte_shreg #(
    .NBYTES(NBYTES),
    .BYTE_W(BYTE_W)
  ) u_shreg (
    .clk       (clk),
    .clr_i     (rst),
    .shift_en_i(shift_en),
    .din_i     (in_byte),
    .dout_o    (blk_out)
  );

  assign blk_vld   = (state_q == HOLD);
  assign busy      = (state_q == CAPT);
  assign ovf       = ovf_q;
  assign short_err = short_q;

endmodule

// File: tb/tb_aes_byte_collector.sv
// Directed bench for aes_byte_collector with default geometry (16 x 8-bit bytes).
module tb_aes_byte_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_byte;
  logic         in_vld;
  logic         clr;
  logic [127:0] blk_out;
  logic         blk_vld;
  logic         blk_rdy;
  logic         busy;
  logic         ovf;
  logic         short_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_byte_collector dut (
    .clk      (clk),
    .rst      (rst),
    .in_byte  (in_byte),
    .in_vld   (in_vld),
    .clr      (clr),
    .blk_out  (blk_out),
    .blk_vld  (blk_vld),
    .blk_rdy  (blk_rdy),
    .busy     (busy),
    .ovf      (ovf),
    .short_err(short_err)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present n consecutive valid bytes first, first+1, ...
  task automatic feed(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_vld  = 1'b1;
      in_byte = first + 8'(i);
      tick();
    end
  endtask

  initial begin
    int vld_cycles;
    int bad_cycles;

    rst = 1'b1; in_byte = '0; in_vld = 1'b0; clr = 1'b0; blk_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_blk_out", blk_out, '0);
    check("rst_blk_vld", blk_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {ovf, short_err}, 0);

    // Basic block with consumer always ready.
    blk_rdy = 1'b1;
    feed(8'h00, 8);
    check("s1_busy_mid", busy, 1);
    feed(8'h08, 7);
    check("s1_no_vld_early", blk_vld, 0);
    feed(8'h0F, 1);
    in_vld = 1'b0;
    check("s1_blk_vld", blk_vld, 1);
    check("s1_blk_out", blk_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("s1_busy_hold", busy, 0);
    tick();
    check("s1_vld_one_cycle", blk_vld, 0);
    check("s1_flags", {ovf, short_err}, 0);

    // Truncated stream, then clear.
    feed(8'h50, 5);
    in_vld = 1'b0;
    tick();
    check("s2_short_err", short_err, 1);
    check("s2_idle", {busy, blk_vld}, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("s2_clr", short_err, 0);
    // Set event in the same cycle as clr wins.
    feed(8'h60, 2);
    in_vld = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("s2_set_over_clr", short_err, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("s2_clr2", short_err, 0);

    // Held block with consumer stalled; second stream is dropped.
    blk_rdy = 1'b0;
    feed(8'h10, 16);
    in_vld = 1'b0;
    tick();
    check("s3_hold_vld", blk_vld, 1);
    feed(8'h55, 1);
    check("s3_ovf", ovf, 1);
    check("s3_blk_stable", blk_out, 128'h101112131415161718191A1B1C1D1E1F);
    check("s3_still_vld", blk_vld, 1);
    blk_rdy = 1'b1;
    feed(8'h56, 1);
    check("s3_accepted", blk_vld, 0);
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      feed(8'h57, 1);
      if (blk_vld || busy) bad_cycles++;
    end
    check("s3_no_retrigger", bad_cycles, 0);
    check("s3_ovf_sticky", ovf, 1);
    clr = 1'b1;
    in_vld = 1'b0;
    tick();
    clr = 1'b0;
    check("s3_ovf_clr", ovf, 0);

    // Accept coincident with a new start.
    blk_rdy = 1'b0;
    feed(8'h20, 16);
    in_vld = 1'b0;
    tick();
    check("s4_first_blk", blk_out, 128'h202122232425262728292A2B2C2D2E2F);
    blk_rdy = 1'b1;
    feed(8'hA0, 1);
    blk_rdy = 1'b0;
    check("s4_accept_start", {blk_vld, busy}, 2'b01);
    feed(8'hA1, 14);
    check("s4_no_vld_early", blk_vld, 0);
    feed(8'hAF, 1);
    in_vld = 1'b0;
    check("s4_second_vld", blk_vld, 1);
    check("s4_second_blk", blk_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    check("s4_flags", {ovf, short_err}, 0);
    blk_rdy = 1'b1;
    tick();
    check("s4_accepted", blk_vld, 0);

    // Reset in the middle of a capture with in_vld held high.
    feed(8'h30, 7);
    in_byte = 8'h37; rst = 1'b1;
    tick();
    check("s5_rst_out", blk_out, '0);
    check("s5_rst_ctrl", {blk_vld, busy, ovf, short_err}, 0);
    rst = 1'b0;
    feed(8'h40, 1);
    check("s5_restart", busy, 1);
    feed(8'h41, 15);
    in_vld = 1'b0;
    check("s5_blk_vld", blk_vld, 1);
    check("s5_blk_out", blk_out, 128'h404142434445464748494A4B4C4D4E4F);
    check("s5_no_flags", {ovf, short_err}, 0);
    tick();

    // Sticky d_vld: one block only.
    vld_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      feed(8'(8'h70 + i), 1);
      if (blk_vld) vld_cycles++;
    end
    check("s6_one_block", vld_cycles, 1);
    check("s6_no_ovf", ovf, 0);
    in_vld = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
